// File: rtl/fft_pkg.sv
// Shared fixed-point helpers and the packed complex type for the FFT datapath.
`ifndef FFT_CPLX_T
`define FFT_CPLX_T(h) struct packed { logic signed [(h)-1:0] re; logic signed [(h)-1:0] im; }
`endif

package fft_pkg;

   localparam int unsigned AccW = 64;
   typedef logic signed [AccW-1:0] acc_t;

   function automatic int unsigned half_width(input int unsigned width);
      return width / 2;
   endfunction

   function automatic acc_t sat_n(input acc_t x, input int unsigned n);
      acc_t hi;
      acc_t lo;
      hi = (acc_t'(1) <<< (n - 1)) - acc_t'(1);
      lo = -(acc_t'(1) <<< (n - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic logic sat_hit(input acc_t x, input int unsigned n);
      return (x != sat_n(x, n));
   endfunction

   // Arithmetic right shift; with rnd set, adds half an output LSB first (round half up).
   function automatic acc_t round_shift(input acc_t x, input int unsigned sh, input bit rnd);
      acc_t y;
      y = x;
      if (rnd && (sh > 0)) y = x + (acc_t'(1) <<< (sh - 1));
      return y >>> sh;
   endfunction

endpackage

// File: rtl/cmul_pipe.sv
// Complex multiply front end: operand (S1) and product (S2) registers, followed by the
// combinational round, shift and saturate of the twiddled product t = W*B.
module cmul_pipe
   import fft_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ROUND = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_en,
   input  logic                      i_valid,
   input  logic [WIDTH-1:0]          i_a,
   input  logic [WIDTH-1:0]          i_b,
   input  logic [WIDTH-1:0]          i_w,
   input  logic                      i_scale,
   output logic                      o_valid,
   output logic [WIDTH-1:0]          o_a,
   output logic                      o_scale,
   output logic signed [WIDTH/2-1:0] o_t_re,
   output logic signed [WIDTH/2-1:0] o_t_im,
   output logic                      o_t_ovf
);

   localparam int unsigned H = half_width(WIDTH);
   localparam int unsigned P = 2 * H;
   typedef `FFT_CPLX_T(H) cplx_t;

   logic                r_s1_valid;
   logic                r_s1_scale;
   logic [WIDTH-1:0]    r_s1_a;
   cplx_t               r_s1_b;
   cplx_t               r_s1_w;
   logic                r_s2_valid;
   logic                r_s2_scale;
   logic [WIDTH-1:0]    r_s2_a;
   logic signed [P-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
   logic signed [P-1:0] w_br, w_bi, w_wr, w_wi;
   acc_t                w_sum_re, w_sum_im, w_sh_re, w_sh_im, w_sat_re, w_sat_im;
   logic                w_unused;

   // Widen before multiplying so the full 2H-bit product survives (-1 * -1 included).
   assign w_br = P'($signed(r_s1_b.re));
   assign w_bi = P'($signed(r_s1_b.im));
   assign w_wr = P'($signed(r_s1_w.re));
   assign w_wi = P'($signed(r_s1_w.im));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_scale <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_w     <= '0;
         r_s2_valid <= 1'b0;
         r_s2_scale <= 1'b0;
         r_s2_a     <= '0;
         r_p_rr     <= '0;
         r_p_ii     <= '0;
         r_p_ri     <= '0;
         r_p_ir     <= '0;
      end else if (i_en) begin
         r_s1_valid <= i_valid;
         r_s1_scale <= i_scale;
         r_s1_a     <= i_a;
         r_s1_b     <= cplx_t'(i_b);
         r_s1_w     <= cplx_t'(i_w);
         r_s2_valid <= r_s1_valid;
         r_s2_scale <= r_s1_scale;
         r_s2_a     <= r_s1_a;
         r_p_rr     <= w_br * w_wr;
         r_p_ii     <= w_bi * w_wi;
         r_p_ri     <= w_br * w_wi;
         r_p_ir     <= w_bi * w_wr;
      end
   end

   always_comb begin
      w_sum_re = acc_t'(r_p_rr) - acc_t'(r_p_ii);
      w_sum_im = acc_t'(r_p_ri) + acc_t'(r_p_ir);
      w_sh_re  = round_shift(w_sum_re, H - 1, ROUND != 0);
      w_sh_im  = round_shift(w_sum_im, H - 1, ROUND != 0);
      w_sat_re = sat_n(w_sh_re, H);
      w_sat_im = sat_n(w_sh_im, H);
   end

   assign o_valid  = r_s2_valid;
   assign o_a      = r_s2_a;
   assign o_scale  = r_s2_scale;
   assign o_t_re   = w_sat_re[H-1:0];
   assign o_t_im   = w_sat_im[H-1:0];
   assign o_t_ovf  = sat_hit(w_sh_re, H) | sat_hit(w_sh_im, H);
   assign w_unused = ^{w_sat_re[AccW-1:H], w_sat_im[AccW-1:H]};

endmodule

// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly: out_a = A + W*B, out_b = A - W*B, three pipeline stages with a
// single global stall enable driven by output backpressure.
module butterfly_pipe
   import fft_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ROUND = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_w,
   input  logic             in_scale,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             out_ovf
);

   localparam int unsigned H = half_width(WIDTH);
   typedef `FFT_CPLX_T(H) cplx_t;

   logic                w_en;
   logic                w_s2_valid;
   logic                w_s2_scale;
   logic [WIDTH-1:0]    w_s2_a;
   logic signed [H-1:0] w_t_re, w_t_im;
   logic                w_t_ovf;
   cplx_t               w_a;
   acc_t                w_sum [4];
   acc_t                w_res [4];
   logic                w_ovf;
   logic                w_unused;
   logic                r_out_valid;
   logic                r_out_ovf;
   logic [WIDTH-1:0]    r_out_a, r_out_b;

   // Whole pipeline advances together; a stalled output freezes every stage.
   assign w_en     = !r_out_valid || out_ready;
   assign in_ready = w_en;

   cmul_pipe #(
      .WIDTH (WIDTH),
      .ROUND (ROUND)
   ) u_cmul (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_valid (in_valid),
      .i_a     (in_a),
      .i_b     (in_b),
      .i_w     (in_w),
      .i_scale (in_scale),
      .o_valid (w_s2_valid),
      .o_a     (w_s2_a),
      .o_scale (w_s2_scale),
      .o_t_re  (w_t_re),
      .o_t_im  (w_t_im),
      .o_t_ovf (w_t_ovf)
   );

   always_comb begin
      w_a      = cplx_t'(w_s2_a);
      w_sum[0] = acc_t'($signed(w_a.re)) + acc_t'(w_t_re);
      w_sum[1] = acc_t'($signed(w_a.im)) + acc_t'(w_t_im);
      w_sum[2] = acc_t'($signed(w_a.re)) - acc_t'(w_t_re);
      w_sum[3] = acc_t'($signed(w_a.im)) - acc_t'(w_t_im);
      w_ovf    = w_t_ovf;
      for (int i = 0; i < 4; i++) begin
         if (w_s2_scale) begin
            w_res[i] = round_shift(w_sum[i], 1, ROUND != 0);
         end else begin
            w_res[i] = sat_n(w_sum[i], H);
            w_ovf    = w_ovf | sat_hit(w_sum[i], H);
         end
      end
   end

   assign w_unused = ^{w_res[0][AccW-1:H], w_res[1][AccW-1:H],
                       w_res[2][AccW-1:H], w_res[3][AccW-1:H]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_ovf   <= 1'b0;
         r_out_a     <= '0;
         r_out_b     <= '0;
      end else if (w_en) begin
         r_out_valid <= w_s2_valid;
         r_out_ovf   <= w_ovf;
         r_out_a     <= {w_res[0][H-1:0], w_res[1][H-1:0]};
         r_out_b     <= {w_res[2][H-1:0], w_res[3][H-1:0]};
      end
   end

   assign out_valid = r_out_valid;
   assign out_ovf   = r_out_ovf;
   assign out_a     = r_out_a;
   assign out_b     = r_out_b;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Randomised and directed checks of butterfly_pipe (WIDTH=32, ROUND=1) against a
// queue-based arithmetic reference model.
module tb_butterfly_pipe;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0, in_b = '0, in_w = '0;
   logic         in_scale = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_a, out_b;
   logic         out_ovf;

   int total = 0;
   int bad   = 0;
   int n_in  = 0;
   int n_out = 0;
   int rdy_mode = 0;  // 0: always ready, 1: fixed 1,0,0,1,0,1 pattern, 2: random
   int pat_i = 0;
   logic [5:0] pat = 6'b101001;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        ovf;
   } res_t;

   res_t exp_q[$];
   res_t held;
   res_t e;
   logic held_v = 1'b0;

   always #5 clk = ~clk;

   butterfly_pipe #(
      .WIDTH (W),
      .ROUND (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_w      (in_w),
      .in_scale  (in_scale),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_ovf   (out_ovf)
   );

   task automatic chk(input string nm, input logic ok, input string got, input string want);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %s, expected %s", nm, got, want);
      end
   endtask

   // Floor division for positive d.
   function automatic longint fdiv(input longint x, input longint d);
      longint q;
      q = x / d;
      if ((x % d) != 0 && x < 0) q = q - 1;
      return q;
   endfunction

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] w, input logic sc);
      longint ar, ai, br, bi, wr, wi;
      longint t[2];
      longint s[4];
      longint o[4];
      logic   ovf;
      res_t   r;
      ovf = 1'b0;
      ar = longint'($signed(a[31:16])); ai = longint'($signed(a[15:0]));
      br = longint'($signed(b[31:16])); bi = longint'($signed(b[15:0]));
      wr = longint'($signed(w[31:16])); wi = longint'($signed(w[15:0]));
      // Product is Q2.30; round to Q1.15 by adding half an LSB and dividing by 2^15.
      t[0] = fdiv(br * wr - bi * wi + 16384, 32768);
      t[1] = fdiv(br * wi + bi * wr + 16384, 32768);
      for (int i = 0; i < 2; i++) begin
         if (t[i] > 32767) begin t[i] = 32767; ovf = 1'b1; end
         else if (t[i] < -32768) begin t[i] = -32768; ovf = 1'b1; end
      end
      s = '{ar + t[0], ai + t[1], ar - t[0], ai - t[1]};
      for (int i = 0; i < 4; i++) begin
         o[i] = s[i];
         if (sc) o[i] = fdiv(s[i] + 1, 2);
         else if (s[i] > 32767) begin o[i] = 32767; ovf = 1'b1; end
         else if (s[i] < -32768) begin o[i] = -32768; ovf = 1'b1; end
      end
      r.a   = {o[0][15:0], o[1][15:0]};
      r.b   = {o[2][15:0], o[3][15:0]};
      r.ovf = ovf;
      return r;
   endfunction

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: begin out_ready = pat[pat_i % 6]; pat_i++; end
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Scoreboard: everything is sampled on the falling edge, between active edges.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            chk("hold", out_valid && out_a === held.a && out_b === held.b && out_ovf === held.ovf,
                $sformatf("v=%0b a=%h b=%h ovf=%0b", out_valid, out_a, out_b, out_ovf),
                $sformatf("v=1 a=%h b=%h ovf=%0b", held.a, held.b, held.ovf));
         end
         held_v = 1'b0;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("stale", 1'b0, $sformatf("result a=%h b=%h", out_a, out_b), "no result");
            end else if (out_ready) begin
               e = exp_q.pop_front();
               n_out++;
               chk("result", out_a === e.a && out_b === e.b && out_ovf === e.ovf,
                   $sformatf("a=%h b=%h ovf=%0b", out_a, out_b, out_ovf),
                   $sformatf("a=%h b=%h ovf=%0b", e.a, e.b, e.ovf));
            end else begin
               held   = '{out_a, out_b, out_ovf};
               held_v = 1'b1;
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_a, in_b, in_w, in_scale));
            n_in++;
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                       input logic sc);
      logic acc;
      in_valid = 1'b1;
      in_a = a; in_b = b; in_w = w; in_scale = sc;
      do begin
         @(negedge clk);
         acc = in_ready && !rst;
         @(posedge clk);
         #1;
      end while (!acc);
      in_valid = 1'b0;
   endtask

   // Cycles are counted from the cycle the sample is presented with the pipeline ready.
   task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] w, input logic sc, input logic [31:0] ea,
                           input logic [31:0] eb, input logic eo);
      int n;
      send(a, b, w, sc);
      n = 1;
      while (!out_valid && n < 12) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({nm, "_latency"}, n == 3, $sformatf("%0d", n), "3");
      chk({nm, "_a"}, out_a === ea, $sformatf("%h", out_a), $sformatf("%h", ea));
      chk({nm, "_b"}, out_b === eb, $sformatf("%h", out_b), $sformatf("%h", eb));
      chk({nm, "_ovf"}, out_ovf === eo, $sformatf("%0b", out_ovf), $sformatf("%0b", eo));
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rcomp();
      case ($urandom_range(0, 5))
         0: return 16'h8000;
         1: return 16'h7FFF;
         2: return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [31:0] rword();
      return {rcomp(), rcomp()};
   endfunction

   initial begin
      int base_in, base_out, seen;
      // Reset, with a sample presented that must be dropped.
      in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h7FFF_7FFF; in_w = 32'h7FFF_0000;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid === 1'b0, $sformatf("%0b", out_valid), "0");
      chk("rst_a", out_a === 32'h0, $sformatf("%h", out_a), "00000000");
      chk("rst_b", out_b === 32'h0, $sformatf("%h", out_b), "00000000");
      chk("rst_ovf", out_ovf === 1'b0, $sformatf("%0b", out_ovf), "0");
      chk("rst_ready", in_ready === 1'b1, $sformatf("%0b", in_ready), "1");
      in_valid = 1'b0;
      rst = 1'b0;
      seen = 0;
      repeat (5) begin @(posedge clk); #1; if (out_valid) seen++; end
      chk("rst_drop", seen == 0, $sformatf("%0d valid cycles", seen), "0");

      directed("basic", 32'h1000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0,
               32'h3000_0000, 32'hF000_0000, 1'b0);
      directed("scale", 32'h1000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b1,
               32'h1800_0000, 32'hF800_0000, 1'b0);
      directed("imag", 32'h0000_0000, 32'h1000_0000, 32'h0000_8000, 1'b0,
               32'h0000_F000, 32'h0000_1000, 1'b0);
      directed("sat", 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0,
               32'h7FFF_0000, 32'h0001_0000, 1'b1);
      directed("neg1", 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0,
               32'h7FFF_0000, 32'h8001_0000, 1'b1);

      // Backpressure: 8 back-to-back samples under a stall pattern.
      base_out = n_out;
      rdy_mode = 1;
      for (int i = 0; i < 8; i++) send(rword(), rword(), rword(), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 100 && (n_out - base_out) < 8; i++) @(posedge clk);
      #1;
      chk("bp_count", (n_out - base_out) == 8, $sformatf("%0d", n_out - base_out), "8");
      chk("bp_empty", exp_q.size() == 0, $sformatf("%0d left", exp_q.size()), "0 left");
      rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1;

      // Reset while two samples are in flight.
      send(32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 1'b0);
      send(32'h0102_0304, 32'h7FFF_8000, 32'h4000_C000, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_valid", out_valid === 1'b0, $sformatf("%0b", out_valid), "0");
      seen = 0;
      repeat (5) begin @(posedge clk); #1; if (out_valid) seen++; end
      chk("midrst_flush", seen == 0, $sformatf("%0d valid cycles", seen), "0");
      directed("postrst", 32'h1000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0,
               32'h3000_0000, 32'hF000_0000, 1'b0);

      // Random traffic with random backpressure and idle gaps.
      base_in  = n_in;
      base_out = n_out;
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         send(rword(), rword(), rword(), 1'($urandom_range(0, 1)));
      end
      rdy_mode = 0;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("rand_count", (n_out - base_out) == (n_in - base_in),
          $sformatf("%0d out", n_out - base_out), $sformatf("%0d out", n_in - base_in));
      chk("rand_empty", exp_q.size() == 0, $sformatf("%0d left", exp_q.size()), "0 left");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
